// File: rtl/axis_sched_pkg.sv
// Shared definitions for the AXI-stream DMA command scheduler: FSM encoding,
// direction codes and the engines' configuration register numbers.
package axis_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_ADDR = 2'd2,
    ST_LEN  = 2'd3
  } state_t;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  localparam int REG_SEL  = 23;
  localparam int REG_DATA = 24;

endpackage

// File: rtl/axis_sched_if.sv
// Bundle of command, config-bus, stream-monitor and status signals of axis_sched.
// The scheduler uses the slave view; the command source / environment uses master.
interface axis_sched_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [DW-1:0] cmd_addr;
  logic [DW-1:0] cmd_len;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic          rd_valid;
  logic          rd_ready;
  logic          wr_busy;
  logic          rd_busy;
  logic          wr_done;
  logic          rd_done;
  logic          err_timeout;

  modport master (
    output cmd_valid, cmd_dir, cmd_addr, cmd_len,
    output wr_valid, wr_ready, rd_valid, rd_ready,
    input  cmd_ready, cfg_addr, cfg_data, cfg_valid,
    input  wr_busy, rd_busy, wr_done, rd_done, err_timeout
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
    input  wr_valid, wr_ready, rd_valid, rd_ready,
    output cmd_ready, cfg_addr, cfg_data, cfg_valid,
    output wr_busy, rd_busy, wr_done, rd_done, err_timeout
  );
endinterface

// File: rtl/axis_sched_track.sv
// Per-engine transfer tracker: beat countdown, busy flag and done pulse.
// Optional idle-beat watchdog enabled by AXIS_SCHED_TIMEOUT_EN.
module axis_sched_track #(
  parameter int CNT_W = 32
`ifdef AXIS_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             skip,
  input  logic [CNT_W-1:0] len,
  input  logic             beat,
  output logic             busy,
  output logic             done
`ifdef AXIS_SCHED_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  logic [CNT_W-1:0] cnt;

`ifdef AXIS_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic            expire;

  // wd counts consecutive beat-less cycles while busy; expiry drops the transfer
  assign expire = busy && !beat && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (!busy || beat || expire) wd <= '0;
      else                         wd <= wd + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= skip;
      if (start) begin
        cnt  <= len;
        busy <= 1'b1;
      end else if (busy && beat) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
`ifdef AXIS_SCHED_TIMEOUT_EN
      else if (expire) begin
        cnt  <= '0;
        busy <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/axis_sched.sv
// Command scheduler for the write/read AXI-stream DMA engine pair: serialises
// commands onto the config bus and tracks completion. Optional: AXIS_SCHED_TIMEOUT_EN.
module axis_sched
  import axis_sched_pkg::*;
#(
  parameter int CFG_ID_WR  = 1,
  parameter int CFG_ID_RD  = 2,
  parameter int CFG_ADDR   = REG_SEL,
  parameter int CFG_DATA   = REG_DATA,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
`ifdef AXIS_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input logic         clk,
  input logic         rst,
  axis_sched_if.slave bus
);

  state_t                state, state_next;
  logic [1:0]            busy, done, beat, start, skip;
  logic                  accept, len_zero;
  logic [CFG_DWIDTH-1:0] lat_addr, lat_len;
  logic                  cfg_valid_r, cfg_valid_next;
  logic [CFG_AWIDTH-1:0] cfg_addr_r, cfg_addr_next;
  logic [CFG_DWIDTH-1:0] cfg_data_r, cfg_data_next;

  assign bus.cmd_ready = (state == ST_IDLE) && !busy[bus.cmd_dir] && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign len_zero      = (bus.cmd_len == '0);
  assign beat          = {bus.rd_valid & bus.rd_ready, bus.wr_valid & bus.wr_ready};
  assign start         = {accept && !len_zero && (bus.cmd_dir == DIR_RD),
                          accept && !len_zero && (bus.cmd_dir == DIR_WR)};
  assign skip          = {accept && len_zero && (bus.cmd_dir == DIR_RD),
                          accept && len_zero && (bus.cmd_dir == DIR_WR)};

  // Config outputs are decoded from the state being entered, so the word
  // belonging to a state is on the bus for exactly the cycle spent in it.
  always_comb begin
    state_next     = state;
    cfg_valid_next = 1'b0;
    cfg_addr_next  = '0;
    cfg_data_next  = '0;
    case (state)
      ST_IDLE: begin
        if (accept && !len_zero) begin
          state_next     = ST_SEL;
          cfg_valid_next = 1'b1;
          cfg_addr_next  = CFG_AWIDTH'(CFG_ADDR);
          cfg_data_next  = (bus.cmd_dir == DIR_RD) ? CFG_DWIDTH'(CFG_ID_RD)
                                                   : CFG_DWIDTH'(CFG_ID_WR);
        end
      end
      ST_SEL: begin
        state_next     = ST_ADDR;
        cfg_valid_next = 1'b1;
        cfg_addr_next  = CFG_AWIDTH'(CFG_DATA);
        cfg_data_next  = lat_addr;
      end
      ST_ADDR: begin
        state_next     = ST_LEN;
        cfg_valid_next = 1'b1;
        cfg_addr_next  = CFG_AWIDTH'(CFG_DATA);
        cfg_data_next  = lat_len;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg_valid_r <= 1'b0;
      cfg_addr_r  <= '0;
      cfg_data_r  <= '0;
    end else begin
      state       <= state_next;
      cfg_valid_r <= cfg_valid_next;
      cfg_addr_r  <= cfg_addr_next;
      cfg_data_r  <= cfg_data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr <= bus.cmd_addr;
      lat_len  <= bus.cmd_len;
    end
  end

  assign bus.cfg_valid = cfg_valid_r;
  assign bus.cfg_addr  = cfg_addr_r;
  assign bus.cfg_data  = cfg_data_r;

`ifdef AXIS_SCHED_TIMEOUT_EN
  logic [1:0] tout;
`endif

  for (genvar e = 0; e < 2; e++) begin : g_trk
    axis_sched_track #(
      .CNT_W(CFG_DWIDTH)
`ifdef AXIS_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_trk (
      .clk    (clk),
      .rst    (rst),
      .start  (start[e]),
      .skip   (skip[e]),
      .len    (bus.cmd_len),
      .beat   (beat[e]),
      .busy   (busy[e]),
      .done   (done[e])
`ifdef AXIS_SCHED_TIMEOUT_EN
      ,
      .timeout(tout[e])
`endif
    );
  end

  assign bus.wr_busy = busy[0];
  assign bus.rd_busy = busy[1];
  assign bus.wr_done = done[0];
  assign bus.rd_done = done[1];

`ifdef AXIS_SCHED_TIMEOUT_EN
  assign bus.err_timeout = |tout;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axis_sched.sv
// Bench for axis_sched: directed scenarios plus random traffic, all checked
// against a queue/counter model of the scheduler's externally visible rules.
module tb_axis_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_sched_if #(.AW(5), .DW(32)) bus ();

  axis_sched #(
    .CFG_ID_WR(1), .CFG_ID_RD(2), .CFG_ADDR(23), .CFG_DATA(24),
    .CFG_AWIDTH(5), .CFG_DWIDTH(32)
`ifdef AXIS_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef AXIS_SCHED_TIMEOUT_EN
  localparam int TO_LIM = 32;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model: pending config words, word on the bus now, beats remaining per engine
  logic [36:0] q[$];
  logic [36:0] seen[$];
  logic        shown = 1'b0;
  logic [36:0] cur = '0;
  int          rem[2] = '{0, 0};
  int          idle[2] = '{0, 0};
  logic [1:0]  edone = '0;
  logic        eto = 1'b0;
  logic        last_acc = 1'b0;
  int          acc_cyc = 0;
  int          wr_done_cnt = 0;
  int          rd_done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        exp_ready, acc, dir;
    logic [31:0] len, addr;
    logic [1:0]  bt;
    logic [42:0] exp_o, obs_o;
    #1;
    exp_ready = !rst && !shown && (q.size() == 0) && (rem[int'(bus.cmd_dir)] == 0);
    check("cmd_ready", 64'(bus.cmd_ready), 64'(exp_ready));
    acc  = bus.cmd_valid && exp_ready;
    dir  = bus.cmd_dir;
    len  = bus.cmd_len;
    addr = bus.cmd_addr;
    bt   = {bus.rd_valid & bus.rd_ready, bus.wr_valid & bus.wr_ready};
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    if (acc) acc_cyc = cyc;
    if (rst) begin
      q.delete();
      shown = 1'b0; cur = '0; edone = '0; eto = 1'b0;
      rem[0] = 0; rem[1] = 0; idle[0] = 0; idle[1] = 0;
    end else begin
      eto = 1'b0;
      for (int e = 0; e < 2; e++) begin
        edone[e] = 1'b0;
        if (acc && int'(dir) == e) begin
          if (len == 0) edone[e] = 1'b1;
          else begin rem[e] = int'(len); idle[e] = 0; end
        end else if (rem[e] > 0) begin
          if (bt[e]) begin
            rem[e]--; idle[e] = 0;
            if (rem[e] == 0) edone[e] = 1'b1;
          end
`ifdef AXIS_SCHED_TIMEOUT_EN
          else begin
            idle[e]++;
            if (idle[e] == TO_LIM) begin rem[e] = 0; idle[e] = 0; eto = 1'b1; end
          end
`endif
        end
      end
      if (acc && len != 0) begin
        q.push_back({5'd23, (dir ? 32'd2 : 32'd1)});
        q.push_back({5'd24, addr});
        q.push_back({5'd24, len});
      end
      if (q.size() != 0) begin cur = q.pop_front(); shown = 1'b1; end
      else begin cur = '0; shown = 1'b0; end
    end
    exp_o = {shown, cur, rem[1] != 0, rem[0] != 0, edone[1], edone[0], eto};
    obs_o = {bus.cfg_valid, bus.cfg_addr, bus.cfg_data, bus.rd_busy, bus.wr_busy,
             bus.rd_done, bus.wr_done, bus.err_timeout};
    check("outputs", 64'(obs_o), 64'(exp_o));
    if (bus.cfg_valid) seen.push_back({bus.cfg_addr, bus.cfg_data});
    wr_done_cnt += int'(bus.wr_done);
    rd_done_cnt += int'(bus.rd_done);
  endtask

  task automatic quiet();
    bus.cmd_valid = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_ready = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_ready = 1'b0;
  endtask

  task automatic send(input logic d, input logic [31:0] a, input logic [31:0] l);
    int n = 0;
    bus.cmd_dir = d; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_valid = 1'b1;
    do begin step(); n++; end while (!last_acc && n < 300);
    check("accept_bound", 64'(last_acc), 64'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic beats(input int e, input int n);
    for (int i = 0; i < n; i++) begin
      if (e == 0) begin bus.wr_valid = 1'b1; bus.wr_ready = 1'b1; end
      else        begin bus.rd_valid = 1'b1; bus.rd_ready = 1'b1; end
      step();
    end
    quiet();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, n1, k;
    rst = 1'b1;
    quiet();
    bus.cmd_dir = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    step(); step();
    check("reset_ready", 64'(bus.cmd_ready), 64'd0);
    check("reset_outs", 64'({bus.cfg_valid, bus.cfg_addr, bus.cfg_data, bus.wr_busy,
                             bus.rd_busy, bus.wr_done, bus.rd_done, bus.err_timeout}), 64'd0);
    rst = 1'b0;
    step();

    // basic write: three config words back to back, then 16 beats
    seen.delete();
    send(1'b0, 32'h1000_0000, 32'd16);
    step(); step();
    check("cfg_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      check("cfg_sel",  64'(seen[0]), 64'({5'd23, 32'd1}));
      check("cfg_addr", 64'(seen[1]), 64'({5'd24, 32'h1000_0000}));
      check("cfg_len",  64'(seen[2]), 64'({5'd24, 32'd16}));
    end
    check("wr_busy_set", 64'(bus.wr_busy), 64'd1);
    n0 = wr_done_cnt;
    beats(0, 16);
    check("wr_done_once", 64'(wr_done_cnt - n0), 64'd1);
    check("wr_busy_clear", 64'(bus.wr_busy), 64'd0);

    // concurrent engines; second write held until the first drains
    send(1'b0, 32'h2000, 32'd64);
    n1 = acc_cyc;
    send(1'b1, 32'h3000, 32'd8);
    check("rd_accept_gap", 64'(acc_cyc - n1), 64'd4);
    n0 = wr_done_cnt; n1 = rd_done_cnt;
    bus.cmd_dir = 1'b0; bus.cmd_addr = 32'h4000; bus.cmd_len = 32'd5; bus.cmd_valid = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_ready = 1'b1; bus.rd_valid = 1'b1; bus.rd_ready = 1'b1;
    k = 0;
    do begin step(); k++; end while (!last_acc && k < 300);
    check("wr_held_accept", 64'(last_acc), 64'd1);
    check("wr_held_until_done", 64'(wr_done_cnt - n0), 64'd1);
    check("rd_done_once", 64'(rd_done_cnt - n1), 64'd1);
    quiet();
    beats(0, 5);
    check("wr2_drained", 64'(bus.wr_busy), 64'd0);

    // zero-length command
    step();
    seen.delete();
    send(1'b0, 32'h5000, 32'd0);
    check("zero_len_done", 64'(bus.wr_done), 64'd1);
    check("zero_len_busy", 64'(bus.wr_busy), 64'd0);
    step(); step();
    check("zero_len_no_cfg", 64'(seen.size()), 64'd0);

    // last beats of both engines in the same cycle
    send(1'b0, 32'h5100, 32'd3);
    send(1'b1, 32'h5200, 32'd3);
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_ready = 1'b1; bus.rd_valid = 1'b1; bus.rd_ready = 1'b1;
      step();
    end
    quiet();
    check("dual_done", 64'({bus.wr_done, bus.rd_done}), 64'd3);
    check("dual_busy", 64'({bus.wr_busy, bus.rd_busy}), 64'd0);
    step();

    // reset while the address word is on the bus
    seen.delete();
    send(1'b0, 32'h6000, 32'd10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_cfg_valid", 64'(bus.cfg_valid), 64'd0);
    check("rst_wr_busy", 64'(bus.wr_busy), 64'd0);
    step();
    check("rst_no_len", 64'(seen.size()), 64'd2);
    send(1'b1, 32'h7000, 32'd2);
    beats(1, 2);
    check("post_rst_drain", 64'(bus.rd_busy), 64'd0);

`ifdef AXIS_SCHED_TIMEOUT_EN
    // watchdog: read of 4 with only 2 beats
    n0 = rd_done_cnt;
    send(1'b1, 32'h8000, 32'd4);
    beats(1, 2);
    k = 0;
    do begin step(); k++; end while (!bus.err_timeout && k < 100);
    check("timeout_latency", 64'(k), 64'd32);
    check("timeout_rd_busy", 64'(bus.rd_busy), 64'd0);
    check("timeout_no_done", 64'(rd_done_cnt - n0), 64'd0);
    step();
`endif

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.cmd_valid = 1'($urandom);
      bus.cmd_dir   = 1'($urandom);
      bus.cmd_addr  = $urandom;
      bus.cmd_len   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 24));
      bus.wr_valid  = 1'($urandom);
      bus.wr_ready  = ($urandom_range(0, 3) != 0);
      bus.rd_valid  = 1'($urandom);
      bus.rd_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    quiet();
    for (int i = 0; i < 5; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_sched.md
Name: axis_sched

Overview:
- Command-driven controller for the AXI stream DMA engine pair (write path, read path).
- Accepts transfer commands (direction, start address, word count) on a valid/ready port.
- Serialises each command into the three-word configuration-bus sequence the engines consume.
- Tracks completion by counting stream beats; blocks a new command to an engine until that engine's previous transfer has drained.

Parameters:
- CFG_ID_WR, 1, engine select ID of write path
- CFG_ID_RD, 2, engine select ID of read path
- CFG_ADDR, 23, config register address: engine select
- CFG_DATA, 24, config register address: data words (address, then length)
- CFG_AWIDTH, 5, config address width
- CFG_DWIDTH, 32, config data width; also cmd_addr/cmd_len width
- TIMEOUT_CYCLES, 4096, idle-beat watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_dir  in  1  0 = write path, 1 = read path
- cmd_addr  in  CFG_DWIDTH  byte start address
- cmd_len  in  CFG_DWIDTH  transfer length in stream words
- cfg_addr  out  CFG_AWIDTH  config bus address
- cfg_data  out  CFG_DWIDTH  config bus data
- cfg_valid  out  1  config bus strobe, one word per cycle
- wr_valid, wr_ready  in  1 each  write-stream handshake monitor
- rd_valid, rd_ready  in  1 each  read-stream handshake monitor
- wr_busy, rd_busy  out  1 each  transfer outstanding on that engine
- wr_done, rd_done  out  1 each  single-cycle completion pulse
- err_timeout  out  1  single-cycle watchdog pulse

Behaviour:
- Reset values: cmd_ready, cfg_valid, wr_busy, rd_busy, wr_done, rd_done and err_timeout are 0; cfg_addr and cfg_data are 0; FSM is IDLE; both counters are 0.
- Reset mid-sequence aborts the sequence and clears all tracking.
- FSM states: IDLE, SEL, ADDR, LEN.
- cmd_ready = (state==IDLE) & !busy[cmd_dir] & !rst. It is combinational on cmd_dir.
- Accept with cmd_len != 0:
  - The latched command is registered.
  - The busy bit for the selected engine is set on the next edge.
  - The counter for that engine loads cmd_len.
  - FSM goes IDLE -> SEL.
- SEL: cfg_valid=1, cfg_addr=CFG_ADDR, cfg_data=CFG_ID_WR or CFG_ID_RD (zero-extended). Next state ADDR.
- ADDR: cfg_valid=1, cfg_addr=CFG_DATA, cfg_data=latched address. Next state LEN.
- LEN: cfg_valid=1, cfg_addr=CFG_DATA, cfg_data=latched length. Next state IDLE.
- Config outputs are registered. The three words appear on cycles N+1, N+2, N+3 for an accept at cycle N. There are no gaps. The next accept is possible at N+4 (other engine only, or the same engine if it has already drained).
- Accept with cmd_len == 0: no config words, busy is not set, the done pulse for that direction is raised at N+1, FSM stays IDLE.
- Beat counting:
  - The counter decrements on each monitored handshake (valid&ready) while busy, including during the SEL/ADDR/LEN cycles.
  - Beats arriving while not busy are ignored. The counter never underflows.
  - When the counter goes from 1 to 0, busy clears and the done pulse is raised on the same edge.
  - The same engine is accepted again no earlier than the following cycle.
- Both engines run concurrently. Done events on both paths in the same cycle produce both pulses.

Optional Feature:
- AXIS_SCHED_TIMEOUT_EN:
  - Defined: each busy engine has a watchdog counter, cleared on every beat of that engine and on accept.
  - When it reaches TIMEOUT_CYCLES: err_timeout pulses for 1 cycle, that engine's busy and counter clear, and no done pulse is raised.
  - If both engines time out in the same cycle, a single pulse is raised.
- Undefined: err_timeout is tied to 0 and there is no watchdog logic.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE/SEL/ADDR/LEN)
  - direction constants DIR_WR=0, DIR_RD=1
  - the default CFG_ADDR/CFG_DATA register numbers, shared with the engines
- One natural sub-module: axis_sched_track.
  - Per-engine beat counter, busy flag and done pulse, with optional watchdog.
  - Instantiated twice.

Test Plan:
- Reset, then write cmd addr=0x1000_0000, len=16 -> cfg words (23,1), (24,0x10000000), (24,16) on consecutive cycles; wr_busy=1; after 16 wr beats, wr_done pulses once and wr_busy=0.
- Read cmd len=8 while a write of len=64 is busy -> read accepted at N+4, both engines tracked; second write cmd held (cmd_ready=0) until wr_done.
- len=0 write cmd -> no cfg_valid, wr_done at N+1, wr_busy stays 0.
- Last wr beat and last rd beat in the same cycle -> wr_done and rd_done pulse together; both busy bits clear.
- Assert rst during ADDR -> cfg_valid=0 next cycle, busy=0, no LEN word issued; a fresh command is accepted after reset.
- With AXIS_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=32: read len=4, only 2 beats supplied -> err_timeout pulses 32 cycles after the last beat, rd_busy=0, no rd_done.
